// File: rtl/avalon_sdram_responder.sv
// Avalon-MM 16-bit SDRAM stand-in backed by on-chip RAM, self-initialised to mem[i]=i.
// Reads return READ_LATENCY cycles after acceptance, in order; waitrequest stalls each command WAIT_CYCLES cycles.
module avalon_sdram_responder #(
  parameter int          DEPTH_LOG2   = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          WAIT_CYCLES  = 1,
  parameter int          READ_LATENCY = 2,
  parameter logic [15:0] BAD_DATA     = 16'hDEAD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [1:0]  byteenable,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] address,
  input  logic [15:0] writedata,
  output logic        waitrequest,
  output logic        readdatavalid,
  output logic [15:0] readdata,
  output logic        ready,
  output logic        err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state;
  logic [DEPTH_LOG2-1:0]   init_idx;
  logic [3:0]              wait_cnt;
  logic [15:0]             mem [DEPTH];
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [15:0]             pipe_dat [READ_LATENCY];

  logic                  cmd, accept, acc_rd, acc_wr, acc_both, in_range;
  logic [31:0]           word_idx;
  logic [DEPTH_LOG2-1:0] widx;
  logic [15:0]           rd_sample;

  assign cmd         = chipselect && (!read_n || !write_n);
  assign waitrequest = (state == INIT) || (cmd && (wait_cnt != WAIT_LIM));
  assign accept      = cmd && !waitrequest;
  assign acc_both    = accept && !read_n && !write_n;
  assign acc_rd      = accept && !read_n && write_n;
  assign acc_wr      = accept && read_n && !write_n;

  assign word_idx  = (address - BASE_ADDR) >> 1;
  assign in_range  = (address >= BASE_ADDR) && !address[0] && (word_idx < 32'(DEPTH));
  assign widx      = word_idx[DEPTH_LOG2-1:0];
  // Asynchronous read so a write committed on the previous edge is visible to this accept.
  assign rd_sample = in_range ? mem[widx] : BAD_DATA;

  // Last pipeline stage doubles as the output register; its data only loads on valid, so readdata holds.
  assign readdatavalid = pipe_vld[READ_LATENCY-1];
  assign readdata      = pipe_dat[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_idx] <= 16'(init_idx);
    end else if (reset_n && acc_wr && in_range) begin
      if (byteenable[0]) mem[widx][7:0]  <= writedata[7:0];
      if (byteenable[1]) mem[widx][15:8] <= writedata[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= INIT;
      init_idx <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      rd_count <= 16'd0;
      wr_count <= 16'd0;
      wait_cnt <= 4'd0;
      pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_dat[i] <= 16'd0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) pipe_dat[i] <= pipe_dat[i-1];
      end
      pipe_vld[0] <= acc_rd;
      if (acc_rd) pipe_dat[0] <= rd_sample;

      case (state)
        INIT: begin
          init_idx <= init_idx + DEPTH_LOG2'(1);
          if (init_idx == '1) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          wait_cnt <= (cmd && !accept) ? wait_cnt + 4'd1 : 4'd0;
          if (acc_both || (accept && !in_range)) err <= 1'b1;
          if (acc_rd) rd_count <= rd_count + 16'd1;
          if (acc_wr) wr_count <= wr_count + 16'd1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_sdram_responder.sv
// Directed bench: dut_a has one wait state and latency 2, dut_b has no wait states and latency 3; both share stimulus.
module tb_avalon_sdram_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic [1:0]  byteenable;
  logic        read_n, write_n;
  logic [31:0] address;
  logic [15:0] writedata;

  logic        a_waitrequest, a_readdatavalid, a_ready, a_err;
  logic [15:0] a_readdata, a_rd_count, a_wr_count;
  logic        b_waitrequest, b_readdatavalid, b_ready, b_err;
  logic [15:0] b_readdata, b_rd_count, b_wr_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int          a_acc[$], a_rdv[$], b_acc[$], b_rdv[$];
  logic [15:0] a_dat[$], b_dat[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_sdram_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(1), .READ_LATENCY(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .byteenable(byteenable),
    .read_n(read_n), .write_n(write_n), .address(address), .writedata(writedata),
    .waitrequest(a_waitrequest), .readdatavalid(a_readdatavalid), .readdata(a_readdata),
    .ready(a_ready), .err(a_err), .rd_count(a_rd_count), .wr_count(a_wr_count)
  );

  avalon_sdram_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(0), .READ_LATENCY(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .byteenable(byteenable),
    .read_n(read_n), .write_n(write_n), .address(address), .writedata(writedata),
    .waitrequest(b_waitrequest), .readdatavalid(b_readdatavalid), .readdata(b_readdata),
    .ready(b_ready), .err(b_err), .rd_count(b_rd_count), .wr_count(b_wr_count)
  );

  // Log read accepts and returns with the cycle they occur in.
  always @(negedge clk) begin
    if (chipselect && !read_n && write_n && !a_waitrequest) a_acc.push_back(cyc);
    if (chipselect && !read_n && write_n && !b_waitrequest) b_acc.push_back(cyc);
    if (a_readdatavalid) begin a_rdv.push_back(cyc); a_dat.push_back(a_readdata); end
    if (b_readdatavalid) begin b_rdv.push_back(cyc); b_dat.push_back(b_readdata); end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    a_acc.delete(); a_rdv.delete(); a_dat.delete();
    b_acc.delete(); b_rdv.delete(); b_dat.delete();
  endtask

  task automatic idle(input int n);
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until the selected DUT accepts it.
  task automatic cmd(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [15:0] d, input logic [1:0] be);
    int n = 0;
    bit acc = 1'b0;
    chipselect = 1'b1; read_n = !rd; write_n = !wr;
    address = a; writedata = d; byteenable = be;
    while (!acc && n < 40) begin
      @(negedge clk);
      n++;
      acc = !(sel ? b_waitrequest : a_waitrequest);
    end
    chk("cmd_accept", 32'(acc), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!(a_ready && b_ready) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, n, 16);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    address = 32'h0; writedata = 16'h0; byteenable = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", a_ready, 0);
    chk("rst_rdv", a_readdatavalid, 0);
    chk("rst_rdata", a_readdata, 0);
    chk("rst_err", a_err, 0);
    chk("rst_rdcnt", a_rd_count, 0);
    chk("rst_wrcnt", a_wr_count, 0);
    chk("rst_waitreq", a_waitrequest, 1);

    // Init: ready after 16 cycles; word 5 holds 5.
    reset_n = 1'b1;
    wait_ready("init_cycles");
    clear_logs();
    cmd(0, 1, 0, 32'h0A, 16'h0, 2'b11);
    idle(6);
    chk("t1_n", a_rdv.size(), 1);
    if (a_rdv.size() == 1 && a_acc.size() == 1) begin
      chk("t1_dat", a_dat[0], 16'h0005);
      chk("t1_lat", a_rdv[0] - a_acc[0], 2);
    end

    // One wait state: accepts and returns every other cycle.
    clear_logs();
    for (int i = 0; i < 4; i++) cmd(0, 1, 0, 32'(2 * i), 16'h0, 2'b11);
    idle(6);
    chk("t2_n", a_rdv.size(), 4);
    if (a_rdv.size() == 4 && a_acc.size() == 4) begin
      chk("t2_lat", a_rdv[0] - a_acc[0], 2);
      for (int i = 0; i < 4; i++) begin
        chk("t2_dat", a_dat[i], 32'(i));
        chk("t2_acc_gap", a_acc[i] - a_acc[0], 2 * i);
        chk("t2_rdv_gap", a_rdv[i] - a_rdv[0], 2 * i);
      end
    end
    chk("t2_rdcnt", a_rd_count, 5);

    // Streaming on dut_b: eight back-to-back returns starting 3 cycles after the first accept.
    clear_logs();
    for (int i = 0; i < 8; i++) cmd(1, 1, 0, 32'(2 * i), 16'h0, 2'b11);
    idle(8);
    chk("t3_n", b_rdv.size(), 8);
    if (b_rdv.size() == 8 && b_acc.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t3_dat", b_dat[i], 32'(i));
        chk("t3_cyc", b_rdv[i], b_acc[0] + 3 + i);
      end
    end

    // Byte lanes, read-after-write, and a write that must not disturb an in-flight read.
    clear_logs();
    cmd(1, 0, 1, 32'h4, 16'hABCD, 2'b01);
    cmd(1, 1, 0, 32'h4, 16'h0, 2'b11);
    cmd(1, 0, 1, 32'h4, 16'h1234, 2'b11);
    cmd(1, 1, 0, 32'h4, 16'h0, 2'b11);
    idle(8);
    chk("t4_n", b_rdv.size(), 2);
    if (b_rdv.size() == 2) begin
      chk("t4_lane", b_dat[0], 16'h00CD);
      chk("t4_full", b_dat[1], 16'h1234);
    end
    chk("t4_hold", b_readdata, 16'h1234);

    // Errors on a freshly reset dut_a.
    pulse_reset();
    wait_ready("t5_reinit");
    chk("t5_err0", a_err, 0);
    clear_logs();
    cmd(0, 1, 0, 32'h1, 16'h0, 2'b11);
    cmd(0, 0, 1, 32'h40, 16'hFFFF, 2'b11);
    cmd(0, 1, 1, 32'h0, 16'h5555, 2'b11);
    idle(6);
    chk("t5_n", a_rdv.size(), 1);
    if (a_rdv.size() == 1) chk("t5_bad", a_dat[0], 16'hDEAD);
    chk("t5_err", a_err, 1);
    chk("t5_rdcnt", a_rd_count, 1);
    chk("t5_wrcnt", a_wr_count, 1);
    clear_logs();
    cmd(0, 1, 0, 32'h0, 16'h0, 2'b11);
    cmd(0, 1, 0, 32'h1E, 16'h0, 2'b11);
    idle(6);
    chk("t5_n2", a_rdv.size(), 2);
    if (a_rdv.size() == 2) begin
      chk("t5_w0", a_dat[0], 16'h0000);
      chk("t5_w15", a_dat[1], 16'h000F);
    end
    chk("t5_sticky", a_err, 1);

    // Reset with two reads in flight on dut_b.
    clear_logs();
    cmd(1, 1, 0, 32'h2, 16'h0, 2'b11);
    cmd(1, 1, 0, 32'h4, 16'h0, 2'b11);
    chipselect = 1'b0; read_n = 1'b1;
    pulse_reset();
    chk("t6_ready", b_ready, 0);
    chk("t6_rdcnt", b_rd_count, 0);
    chk("t6_wrcnt", b_wr_count, 0);
    chk("t6_err", b_err, 0);
    wait_ready("t6_reinit");
    chk("t6_no_rdv", b_rdv.size(), 0);
    cmd(1, 1, 0, 32'h4, 16'h0, 2'b11);
    idle(6);
    chk("t6_n", b_rdv.size(), 1);
    if (b_rdv.size() == 1) chk("t6_ram", b_dat[0], 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
